// File: rtl/datatypes_globals_pkg.sv
// Project-wide payload types shared by the receiver-side datapath blocks.
package datatypes_globals_pkg;

    typedef logic [15:0] rtl_data_t;

endpackage

// File: rtl/vr_merge_pkg.sv
// Shared types for the valid/ready round-robin merge stage.
package vr_merge_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } vr_merge_state_t;

endpackage

// File: rtl/vr_sync_fifo.sv
// Per-channel synchronous FIFO with registered ready and occupancy.
// Storage is read combinationally so a word is presentable the cycle after it lands.
module vr_sync_fifo #(
    parameter type DATA_T = datatypes_globals_pkg::rtl_data_t,
    parameter int  DEPTH  = 4,
    parameter int  CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  DATA_T            push_data,
    input  logic             pop,
    output logic             empty,
    output DATA_T            head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    DATA_T            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ready_q;
    logic             push;

    assign push = push_valid && ready_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Ready looks at the post-edge count, so a full FIFO re-opens one cycle after a pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d < CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign push_ready = ready_q;
    assign empty      = (count_q == '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/valid_ready_rr_merge.sv
// N-channel valid/ready merge: per-channel FIFOs whose heads are round-robin
// arbitrated onto one tagged output, holding the grant while backpressured.
module valid_ready_rr_merge
    import vr_merge_pkg::*;
#(
    parameter type DATA_T = datatypes_globals_pkg::rtl_data_t,
    parameter int  NUM_CH = 4,
    parameter int  DEPTH  = 4,
    parameter int  CH_W   = $clog2(NUM_CH),
    parameter int  CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] in_valid,
    output logic [NUM_CH-1:0] in_ready,
    input  DATA_T             in_data [NUM_CH],
    output logic              out_valid,
    input  logic              out_ready,
    output DATA_T             out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic [CNT_W-1:0]  fill_level [NUM_CH]
);

    vr_merge_state_t  state_q;
    vr_merge_state_t  state_d;
    logic [CH_W-1:0]  lock_ch_q;
    logic [CH_W-1:0]  lock_ch_d;
    logic [CH_W-1:0]  rr_ptr_q;
    logic [CH_W-1:0]  rr_ptr_d;
    logic [CH_W-1:0]  grant;
    logic             any_ne;
    logic             pop;
    logic [NUM_CH-1:0] empty_vec;
    logic [NUM_CH-1:0] pop_vec;
    DATA_T            head_data [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        vr_sync_fifo #(
            .DATA_T (DATA_T),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W)
        ) u_fifo (
            .clk        (clk),
            .reset_n    (reset_n),
            .push_valid (in_valid[gi]),
            .push_ready (in_ready[gi]),
            .push_data  (in_data[gi]),
            .pop        (pop_vec[gi]),
            .empty      (empty_vec[gi]),
            .head_data  (head_data[gi]),
            .count      (fill_level[gi])
        );

        assign pop_vec[gi] = pop && (out_ch == CH_W'(gi));
    end

    // Priority scan starting at rr_ptr and wrapping modulo NUM_CH.
    always_comb begin : p_scan
        int              idx;
        logic [CH_W-1:0] scan_ch;
        grant   = '0;
        any_ne  = 1'b0;
        idx     = 0;
        scan_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            scan_ch = CH_W'(idx);
            if (!any_ne && !empty_vec[scan_ch]) begin
                any_ne = 1'b1;
                grant  = scan_ch;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        out_valid = any_ne;
        out_ch    = grant;
        case (state_q)
            IDLE: begin
                if (any_ne && !out_ready) begin
                    state_d   = LOCKED;
                    lock_ch_d = grant;
                end
            end
            LOCKED: begin
                out_valid = 1'b1;
                out_ch    = lock_ch_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop      = out_valid && out_ready;
    assign out_data = head_data[out_ch];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (pop) begin
            rr_ptr_d = (out_ch == CH_W'(NUM_CH - 1)) ? '0 : out_ch + CH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

endmodule

// File: doc/valid_ready_rr_merge.md
# valid_ready_rr_merge

Single-clock, N-channel valid/ready merge stage. Each of `NUM_CH` input channels is buffered in its own `DEPTH`-entry FIFO, and the FIFO heads are round-robin arbitrated onto one tagged output channel. It sits downstream of the async FIFO wrappers, on the receiver side. There it aggregates several already-synchronised streams into one consumer.

## Interface
Parameters:
- `DATA_T`, default `rtl_data_t`: payload type.
- `NUM_CH`, default 4: input channel count, ≥2.
- `DEPTH`, default 4: entries per channel FIFO, power of two, ≥2.
- `CH_W`, default `$clog2(NUM_CH)`: channel-id width, derived.
- `CNT_W`, default `$clog2(DEPTH+1)`: fill-level width, derived.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  `[NUM_CH]`  per-channel valid.
- `in_ready`  out  `[NUM_CH]`  per-channel ready, registered.
- `in_data`  in  `DATA_T [NUM_CH]`  per-channel payload.
- `out_valid`  out  1  merged valid.
- `out_ready`  in  1  consumer ready.
- `out_data`  out  `DATA_T`  head of the granted channel.
- `out_ch`  out  `CH_W`  index of the granted channel.
- `fill_level`  out  `CNT_W [NUM_CH]`  per-channel occupancy, registered.

## Operation
- Push on channel k: `in_valid[k] && in_ready[k]` at a rising edge; the data is written at `wr_ptr[k]`.
- Pop on channel k: `out_valid && out_ready && out_ch==k`; this advances `rd_ptr[k]`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- `count[k]` is updated as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on a simultaneous push and pop.
- `in_ready[k]` is the registered value of `count_next[k] < DEPTH`.
  - It never depends combinationally on `out_ready`.
  - A full channel therefore re-opens one cycle after a pop.
- There is no empty bypass: a word always lands in the FIFO before it can be presented.
- Arbitration uses a two-state FSM:
  - **IDLE**: `grant` is the first non-empty channel scanning from `rr_ptr` upward (modulo `NUM_CH`). `out_valid` = any channel non-empty.
    - If `out_valid && !out_ready`, latch `grant` into `lock_ch` and go to LOCKED.
  - **LOCKED**: `out_ch = lock_ch`. `out_valid` = 1. Any newly non-empty channel must not change `out_ch` or `out_data`.
    - When `out_ready` is 1, pop and go to IDLE.
- After every pop from channel k, `rr_ptr <= (k+1) mod NUM_CH`.
  - The wrap from `NUM_CH-1` goes to 0.
- The output obeys valid/ready stability: once `out_valid` is high it stays high, with `out_data`/`out_ch` constant, until accepted.

## Timing
- Reset (`reset_n` low, asynchronous) drives:
  - all `count`, `wr_ptr`, `rd_ptr`, `rr_ptr` = 0;
  - FSM = IDLE;
  - `in_ready` = 0, `out_valid` = 0, `fill_level` = 0;
  - `out_ch` = 0, `out_data` = don't-care.
- `in_ready` goes to 1 at the first rising edge after `reset_n` deasserts.
- Pushes presented while `in_ready`=0 are ignored.
- Latency: a word pushed at edge N is visible on `out_valid`/`out_data` in cycle N+1, provided its channel wins arbitration.
- Throughput: one pop per cycle on the output; one push per cycle per channel.
- `fill_level[k]` reflects `count[k]` after the edge.
- Reset mid-operation discards all buffered data.
  - Outputs take their reset values immediately, with no waiting for `clk`.
- A simultaneous push and pop on a full channel is impossible, because `in_ready`=0.
- A simultaneous push and pop on a non-full channel leaves `count` unchanged.

## Structure
- A new `vr_merge_pkg` defines the arbitration FSM enum `vr_merge_state_t {IDLE, LOCKED}`.
- `rtl_data_t` comes from `datatypes_globals_pkg`.
- Sub-module `vr_sync_fifo`, parametrised by `DATA_T` and `DEPTH`, is instantiated `NUM_CH` times via generate. Each instance owns:
  - its storage;
  - `wr_ptr`/`rd_ptr`/`count`;
  - registered ready.
- The top level holds `rr_ptr`, the FSM, `lock_ch` and the priority-rotate scan.

## Test plan
- Reset release: `reset_n` held low 2 cycles -> `in_ready`=0000 and `out_valid`=0 during reset; `in_ready`=1111 one edge after release.
- Single channel fill: push 0x11..0x44 on ch2 with `out_ready`=0 -> `in_ready[2]`=0 after the 4th push, `fill_level[2]`=4. Then raise `out_ready` -> pops 0x11..0x44 in order, and `in_ready[2]`=1 one cycle after the first pop.
- Round-robin fairness: all 4 channels hold 2 words, `out_ready`=1 -> `out_ch` sequence 0,1,2,3,0,1,2,3.
- Lock under backpressure: ch3 pending, `out_ready`=0, then ch0 becomes non-empty -> `out_ch` stays 3 and `out_data` stays stable until `out_ready`=1; next grant is 0.
- Simultaneous push/pop: ch1 at count 2, push and pop in the same cycle -> `fill_level[1]` stays 2, and data order is preserved across pointer wrap (≥6 words through).
- Mid-stream reset: 3 words buffered on ch0, `reset_n` pulsed low between edges -> `out_valid` drops immediately, `fill_level[0]`=0, and the stale words are never output.
